// File: rtl/alu_serial.sv
// -----------------------------------------------------------------------------
// alu_serial
//
// Multi-cycle ALU that processes a WIDTH-bit operand pair SLICE bits per clock.
// One narrow slice datapath is reused N = WIDTH/SLICE times. The ripple carry
// is held in a register between slices. Operands are captured on the input
// handshake. Result and flags are presented with a valid/ready handshake on
// the output side.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set presented
//   in_ready   block can accept operands this cycle
//   a, b       WIDTH-bit operands
//   carry_in   carry/borrow-in used by ADDC/SUBB
//   select     opcode: 000 AND, 001 OR, 010 XOR, 011 NAND,
//                      100 ADD, 101 SUB, 110 ADDC, 111 SUBB
//   out_valid  result and flags valid
//   out_ready  consumer accepts result
//   out        WIDTH-bit result
//   carry_out  carry out of the MSB slice (0 for logic ops)
//   overflow   signed overflow (0 for logic ops)
//   zero       out == 0
//   negative   out[WIDTH-1]
// -----------------------------------------------------------------------------
module alu_serial #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic [2:0]       select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int N  = WIDTH / SLICE;
   // Keep the counter at least one bit wide so SLICE == WIDTH still elaborates.
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] res_reg;
   logic [WIDTH-1:0] res_next;
   logic             carry_reg;
   logic [CW-1:0]    count;

   logic             accept;
   logic             last;
   logic             arith;
   logic [SLICE-1:0] a_slice;
   logic [SLICE-1:0] b_slice;
   logic [SLICE-1:0] b_eff;
   logic [SLICE-1:0] res_slice;
   logic [SLICE:0]   sum;
   logic             slice_carry;
   logic             msb_carry_in;

   // Carry presented to the first slice for each opcode.
   function automatic logic initial_carry(input logic [2:0] op, input logic cin);
      logic c;
      case (op)
         3'b100:  c = 1'b0;
         3'b101:  c = 1'b1;
         3'b110:  c = cin;
         3'b111:  c = cin;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

   // Bitwise operations selected by the low two opcode bits.
   function automatic logic [SLICE-1:0] logic_op(input logic [1:0]       op,
                                                 input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y);
      logic [SLICE-1:0] r;
      case (op)
         2'b00:   r = x & y;
         2'b01:   r = x | y;
         2'b10:   r = x ^ y;
         default: r = ~(x & y);
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // Back-to-back: a new operand set can be taken on the same edge
            // that the consumer takes the current result.
            in_ready  = out_ready;
            if (out_ready) begin
               state_next = in_valid ? BUSY : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign accept = in_valid && in_ready;
   assign last   = (count == CW'(N - 1));

   // ---------------------------------------------------------------------------
   // Slice datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int i = 0; i < N; i++) begin
         if (count == CW'(i)) begin
            a_slice = a_reg[i*SLICE +: SLICE];
            b_slice = b_reg[i*SLICE +: SLICE];
         end
      end
   end

   // Opcode bit 2 selects arithmetic; bit 0 selects subtraction (a + ~b).
   assign arith        = op_reg[2];
   assign b_eff        = op_reg[0] ? ~b_slice : b_slice;
   assign sum          = {1'b0, a_slice} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_reg};
   assign res_slice    = arith ? sum[SLICE-1:0] : logic_op(op_reg[1:0], a_slice, b_slice);
   assign slice_carry  = arith & sum[SLICE];
   // The carry entering a bit equals a ^ b ^ sum at that bit.
   assign msb_carry_in = a_slice[SLICE-1] ^ b_eff[SLICE-1] ^ sum[SLICE-1];

   always_comb begin
      res_next = res_reg;
      for (int i = 0; i < N; i++) begin
         if (count == CW'(i)) begin
            res_next[i*SLICE +: SLICE] = res_slice;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Operand capture (data only, no reset needed)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg  <= a;
         b_reg  <= b;
         op_reg <= select;
      end
   end

   // ---------------------------------------------------------------------------
   // Result, carry chain and flag registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         carry_reg <= 1'b0;
         res_reg   <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
      end else if (accept) begin
         count     <= '0;
         carry_reg <= initial_carry(select, carry_in);
      end else if (state == BUSY) begin
         res_reg   <= res_next;
         carry_reg <= slice_carry;
         count     <= last ? '0 : count + CW'(1);
         if (last) begin
            carry_out <= slice_carry;
            overflow  <= arith & (msb_carry_in ^ sum[SLICE]);
            zero      <= (res_next == '0);
            negative  <= res_next[WIDTH-1];
         end
      end
   end

   // The result register holds the last value through IDLE.
   assign out = res_reg;

endmodule
